// File: rtl/life_grid_engine.sv
// Life-like cellular automaton over a ROWS x COLS grid with programmable birth/survive masks.
// Optional toroidal neighbourhood: define LIFE_GRID_WRAP_EN (default build: off-grid cells are dead).
module life_grid_engine #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int GEN_W = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load,
  input  logic [ROWS*COLS-1:0]               state_0,
  input  logic [8:0]                         birth_mask,
  input  logic [8:0]                         survive_mask,
  input  logic [GEN_W-1:0]                   run_gens,
  input  logic                               start,
  input  logic                               ena,
  output logic                               busy,
  output logic                               done,
  output logic                               stable,
  output logic [ROWS*COLS-1:0]               state_q,
  output logic [GEN_W-1:0]                   gen_count,
  output logic [$clog2(ROWS*COLS+1)-1:0]     population,
  output logic [1:0]                         dbg_state
);

  localparam int N  = ROWS * COLS;
  localparam int PW = $clog2(ROWS * COLS + 1);

  // Handshake: load/start are single-cycle requests honoured only in IDLE;
  // done is a one-cycle pulse, busy is high exactly while the FSM is in RUN.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [N-1:0]     state_d, next_grid;
  logic [GEN_W-1:0] gen_count_q, gen_count_d;
  logic [GEN_W-1:0] remaining_q, remaining_d;
  logic [8:0]       birth_q, birth_d, survive_q, survive_d;
  logic [PW-1:0]    population_q, population_d;
  logic             stable_q, stable_d;
  logic             done_q, done_d;
  logic             step, halt, next_same, accept_load, accept_start;

  function automatic logic cell_at(input logic [N-1:0] g, input int r, input int c);
    logic [N-1:0] sh;
`ifdef LIFE_GRID_WRAP_EN
    int rr;
    int cc;
    rr = (r + ROWS) % ROWS;
    cc = (c + COLS) % COLS;
    sh = g >> (rr * COLS + cc);
    return sh[0];
`else
    if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 1'b0;
    sh = g >> (r * COLS + c);
    return sh[0];
`endif
  endfunction

  function automatic logic [PW-1:0] popcount(input logic [N-1:0] v);
    logic [PW-1:0] cnt;
    logic [N-1:0]  t;
    cnt = '0;
    t   = v;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + {{(PW-1){1'b0}}, t[0]};
      t   = t >> 1;
    end
    return cnt;
  endfunction

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [3:0] nbr_cnt;
      always_comb begin
        nbr_cnt = 4'd0;
        for (int k = 0; k < 9; k++) begin
          if (k != 4) nbr_cnt = nbr_cnt + {3'b000, cell_at(state_q, r + k / 3 - 1, c + k % 3 - 1)};
        end
      end
      assign next_grid[r*COLS+c] = state_q[r*COLS+c] ? survive_q[nbr_cnt] : birth_q[nbr_cnt];
    end
  end

  assign step         = (fsm_q == S_RUN) && ena;
  assign next_same    = (next_grid == state_q);
  assign halt         = step && ((remaining_q == GEN_W'(1)) || next_same);
  assign accept_load  = (fsm_q == S_IDLE) && load;
  assign accept_start = (fsm_q == S_IDLE) && start && !load;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q        <= S_IDLE;
      state_q      <= '0;
      gen_count_q  <= '0;
      remaining_q  <= '0;
      birth_q      <= '0;
      survive_q    <= '0;
      population_q <= '0;
      stable_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      state_q      <= state_d;
      gen_count_q  <= gen_count_d;
      remaining_q  <= remaining_d;
      birth_q      <= birth_d;
      survive_q    <= survive_d;
      population_q <= population_d;
      stable_q     <= stable_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE:  if (accept_start && (run_gens != '0)) fsm_d = S_RUN;
      S_RUN:   if (halt) fsm_d = S_DONE;
      S_DONE:  fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    gen_count_d  = gen_count_q;
    remaining_d  = remaining_q;
    birth_d      = birth_q;
    survive_d    = survive_q;
    population_d = population_q;
    stable_d     = stable_q;
    // A zero-length run still acknowledges with a done pulse.
    done_d       = halt || (accept_start && (run_gens == '0));
    if (accept_load) begin
      state_d      = state_0;
      gen_count_d  = '0;
      stable_d     = 1'b0;
      population_d = popcount(state_0);
    end
    if (accept_start) begin
      birth_d     = birth_mask;
      survive_d   = survive_mask;
      remaining_d = run_gens;
    end
    if (step) begin
      state_d      = next_grid;
      gen_count_d  = gen_count_q + GEN_W'(1);
      remaining_d  = remaining_q - GEN_W'(1);
      population_d = popcount(next_grid);
      stable_d     = next_same;
    end
  end

  always_comb begin
    busy       = (fsm_q == S_RUN);
    done       = done_q;
    stable     = stable_q;
    gen_count  = gen_count_q;
    population = population_q;
    dbg_state  = fsm_q;
  end

endmodule
